mulu_seq_x6y6: RTL and testbench
================================

MULU_SEQ_X6Y6 -- requirements
Module: mulu_seq_x6y6

Interface
Parameters: none. All widths are package constants.
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  an operand pair is offered on x/y.
REQ-004 in_ready  output  1  block can accept an operand pair.
REQ-005 x  input  6  unsigned multiplicand; sampled only on the accept edge.
REQ-006 y  input  6  unsigned multiplier; sampled only on the accept edge.
REQ-007 out_valid  output  1  p holds a completed product.
REQ-008 out_ready  input  1  consumer takes p.
REQ-009 p  output  12  unsigned product x*y.
REQ-010 busy  output  1  operation in progress; equals (state != IDLE).

Function
REQ-011 FSM states SHALL be IDLE, MUL and DONE.
REQ-012 IDLE: in_ready=1. On in_valid&&in_ready: capture x/y into operand registers, clear acc, set step=0, go to MUL.
REQ-013 Slice definitions: xL=x[2:0], xH=x[5:3], yL=y[2:0], yH=y[5:3].
REQ-014 MUL: each cycle uses one internal 3x3 multiplier instance and adds acc += partial<<shift, sequenced by a 2-bit step counter:
- step0: xL*yL, shift 0
- step1: xH*yL, shift 3
- step2: xL*yH, shift 3
- step3: xH*yH, shift 6
REQ-015 After the step3 edge, the state SHALL be DONE. step wraps to 0. No other MUL exit exists.
REQ-016 acc SHALL be 12 bits with no overflow handling; the maximum is 63*63=3969 < 4096.
REQ-017 DONE: out_valid=1 and p=acc. p SHALL stay stable until out_valid&&out_ready, which returns the FSM to IDLE.
REQ-018 in_ready SHALL be 0 in MUL and DONE. in_valid in those states SHALL be ignored and SHALL NOT be captured.
REQ-019 Latency: out_valid rises exactly 4 cycles after the accept edge. The minimum accept-to-accept spacing is 6 cycles.
REQ-020 x/y changes after the accept edge SHALL NOT affect the result.
REQ-021 Outside DONE, out_valid=0 and p=0.
REQ-022 There SHALL be no combinational path from in_valid or out_ready to any output. in_ready, out_valid, p and busy SHALL decode from registers only.

Reset
REQ-023 rst_n low SHALL asynchronously force:
- state=IDLE, step=0, acc=0, operand registers=0
- out_valid=0, p=0, busy=0, in_ready=1
REQ-024 Reset asserted in MUL or DONE SHALL abort the operation. No stale out_valid or partial p SHALL appear after release.
REQ-025 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package mulu_seq_pkg SHALL hold:
- SLICE_W=3, OP_W=6, PROD_W=12
- PP_W=6 (partial-product width)
- the state enum {IDLE, MUL, DONE}
REQ-027 mulu_seq_x6y6 SHALL instantiate exactly one mulu_x3y3 as its sole sub-module. Slice and shift selection muxes SHALL be local combinational logic.
REQ-028 The block SHALL be synthesizable with no latches and a single clock domain.

Verification
REQ-029 Reset, then x=63, y=63 with in_valid -> out_valid 4 cycles after accept, p=3969. With out_ready=1 -> IDLE next cycle.
REQ-030 x=0, y=45 -> p=0. Then x=5, y=9 -> p=45. Then x=7, y=56 -> p=392.
REQ-031 Back-pressure: x=12, y=34, out_ready=0 for 3 cycles -> p=408 held, out_valid held, in_ready=0. A second in_valid offered during this time is not captured.
REQ-032 rst_n pulsed low at step2 of x=50, y=61 -> out_valid=0, in_ready=1 immediately. The next op x=50, y=61 -> p=3050.
REQ-033 Back-to-back: in_valid held high with ops (12,34) then (50,61), out_ready=1 -> accepts 6 cycles apart, p=408 then p=3050.
REQ-034 Exhaustive sweep of all 4096 (x,y) pairs with random out_ready stalls -> every p equals x*y and no result is dropped or duplicated.

Source files
------------

// File: rtl/mulu_seq_pkg.sv
// Shared widths and FSM state encoding for the sequential 6x6 unsigned multiplier.
package mulu_seq_pkg;

    localparam int unsigned SLICE_W = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned PROD_W  = 12;
    localparam int unsigned PP_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : mulu_seq_pkg

// File: rtl/mulu_x3y3.sv
// Combinational 3x3 unsigned multiplier producing one partial product per cycle.
module mulu_x3y3
    import mulu_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic [PP_W-1:0]    p_c
);

    assign p_c = PP_W'(a) * PP_W'(b);

endmodule : mulu_x3y3

// File: rtl/mulu_seq_x6y6.sv
// Sequential 6x6 unsigned multiplier: four 3x3 partial products accumulated
// over four cycles, with valid/ready handshakes on both sides.
module mulu_seq_x6y6
    import mulu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     xop_q, xop_d;
    logic [OP_W-1:0]     yop_q, yop_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic                busy_q, busy_d;

    logic [SLICE_W-1:0]  x_sl, y_sl;
    logic [PP_W-1:0]     pp;
    logic [3:0]          shamt;
    logic [PROD_W-1:0]   pp_shifted;

    // step[0] picks the x slice, step[1] the y slice
    assign x_sl = step_q[0] ? xop_q[OP_W-1:SLICE_W] : xop_q[SLICE_W-1:0];
    assign y_sl = step_q[1] ? yop_q[OP_W-1:SLICE_W] : yop_q[SLICE_W-1:0];

    mulu_x3y3 u_mul (
        .a   (x_sl),
        .b   (y_sl),
        .p_c (pp)
    );

    always_comb begin
        shamt = 4'd0;
        case (step_q)
            2'd0:    shamt = 4'd0;
            2'd1,
            2'd2:    shamt = 4'd3;
            default: shamt = 4'd6;
        endcase
        pp_shifted = PROD_W'(pp) << shamt;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        xop_d   = xop_q;
        yop_d   = yop_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    xop_d   = x;
                    yop_d   = y;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        p_d         = out_valid_d ? acc_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            acc_q       <= '0;
            xop_q       <= '0;
            yop_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            xop_q       <= xop_d;
            yop_q       <= yop_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule : mulu_seq_x6y6

// File: tb/tb_mulu_seq_x6y6.sv
// Directed self-checking bench for the sequential 6x6 multiplier.
module tb_mulu_seq_x6y6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mulu_seq_x6y6 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // Stimulus only: offer one operand pair, wait (bounded) for the result,
    // stall the consumer, then complete the handshake.
    task automatic op(input logic [5:0] a, input logic [5:0] b, input int stall,
                      output logic [11:0] pr, output int lat);
        in_valid = 1'b1;
        x = a;
        y = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 6'($urandom);
        y = 6'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        pr = p;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (p !== 12'd0) begin errors++; $display("FAIL reset_p got=%0d want=0", p); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max();
        logic [11:0] pr;
        int lat;
        op(6'd63, 6'd63, 0, pr, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL max_latency got=%0d want=4", lat); end
        checks++; if (pr !== 12'd3969) begin errors++; $display("FAIL max_p got=%0d want=3969", pr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_idle_out_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL max_idle_in_ready got=%0b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_idle_busy got=%0b want=0", busy); end
        checks++; if (p !== 12'd0) begin errors++; $display("FAIL max_idle_p got=%0d want=0", p); end
    endtask

    task automatic test_vectors();
        logic [5:0]  xa [3];
        logic [5:0]  ya [3];
        logic [11:0] ea [3];
        logic [11:0] pr;
        int lat;
        xa = '{6'd0, 6'd5, 6'd7};
        ya = '{6'd45, 6'd9, 6'd56};
        ea = '{12'd0, 12'd45, 12'd392};
        for (int i = 0; i < 3; i++) begin
            op(xa[i], ya[i], 1, pr, lat);
            checks++; if (pr !== ea[i]) begin errors++; $display("FAIL vec%0d_p got=%0d want=%0d", i, pr, ea[i]); end
            checks++; if (lat != 4) begin errors++; $display("FAIL vec%0d_latency got=%0d want=4", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        x = 6'd12;
        y = 6'd34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 6'd0;
        y = 6'd0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got=%0b want=1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_mul_in_ready got=%0b want=0", in_ready); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid got=%0b want=0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0b want=1", out_valid); end
        checks++; if (p !== 12'd408) begin errors++; $display("FAIL bp_p got=%0d want=408", p); end
        in_valid = 1'b1;
        x = 6'd1;
        y = 6'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got=%0b want=1", i, out_valid); end
            checks++; if (p !== 12'd408) begin errors++; $display("FAIL bp_hold_p%0d got=%0d want=408", i, p); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready%0d got=%0b want=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%0b want=1", in_ready); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_capture_busy got=%0b want=0", busy); end
    endtask

    task automatic test_reset_abort();
        logic [11:0] pr;
        int lat;
        in_valid = 1'b1;
        x = 6'd50;
        y = 6'd61;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%0b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
        #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_stale_valid got=%0b want=0", out_valid); end
        checks++; if (p !== 12'd0) begin errors++; $display("FAIL abort_stale_p got=%0d want=0", p); end
        op(6'd50, 6'd61, 0, pr, lat);
        checks++; if (pr !== 12'd3050) begin errors++; $display("FAIL abort_redo_p got=%0d want=3050", pr); end
        checks++; if (lat != 4) begin errors++; $display("FAIL abort_redo_latency got=%0d want=4", lat); end
    endtask

    task automatic test_back_to_back();
        int          nacc;
        int          nres;
        int          acc_cyc [2];
        logic [11:0] res [2];
        logic        will;
        nacc = 0;
        nres = 0;
        acc_cyc = '{0, 0};
        res = '{12'd0, 12'd0};
        x = 6'd12;
        y = 6'd34;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 40 && nres < 2; c++) begin
            will = in_ready && in_valid;
            @(posedge clk); #1;
            if (will) begin
                if (nacc < 2) acc_cyc[nacc] = c;
                nacc++;
                if (nacc == 1) begin
                    x = 6'd50;
                    y = 6'd61;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (nres < 2) res[nres] = p;
                nres++;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (nacc != 2) begin errors++; $display("FAIL b2b_accepts got=%0d want=2", nacc); end
        checks++; if (nres != 2) begin errors++; $display("FAIL b2b_results got=%0d want=2", nres); end
        checks++; if (acc_cyc[1] - acc_cyc[0] != 6) begin errors++; $display("FAIL b2b_spacing got=%0d want=6", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (res[0] !== 12'd408) begin errors++; $display("FAIL b2b_p0 got=%0d want=408", res[0]); end
        checks++; if (res[1] !== 12'd3050) begin errors++; $display("FAIL b2b_p1 got=%0d want=3050", res[1]); end
    endtask

    task automatic test_sweep();
        logic [11:0] pr;
        logic [11:0] exp_p;
        int lat;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                op(6'(a), 6'(b), int'($urandom_range(0, 2)), pr, lat);
                exp_p = 12'(a * b);
                checks++;
                if (pr !== exp_p || lat != 4) begin
                    errors++;
                    $display("FAIL sweep x=%0d y=%0d got=%0d lat=%0d want=%0d lat=4", a, b, pr, lat, exp_p);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_vectors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mulu_seq_x6y6
